// File: rtl/piso_serializer_handshake.sv
// piso_serializer_handshake: valid/ready parallel-in, MSB-first serial-out with zero-gap word streaming
module piso_serializer_handshake #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic             CE,
  output logic             SO,
  output logic             SO_VALID,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic done_n;
  always_ff @(posedge C or negedge CLR)
    if (!CLR) begin
      state <= IDLE;
      shreg <= {WIDTH{IDLE_LEVEL}};
      cnt   <= '0;
      DONE  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      DONE  <= done_n;
    end
  // ready on the last-bit edge lets the next word follow with no idle cycle
  assign LOAD_READY = CLR & ((state == IDLE) | (cnt == '0 & CE));
  assign SO         = (state == SHIFT) ? shreg[WIDTH-1] : IDLE_LEVEL;
  assign SO_VALID   = state == SHIFT;
  assign BUSY       = state == SHIFT;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (LOAD_VALID) begin
        state_n = SHIFT;
        shreg_n = D;
        cnt_n   = CW'(WIDTH - 1);
      end
    end else if (CE) begin
      if (cnt != '0) begin
        shreg_n = {shreg[WIDTH-2:0], IDLE_LEVEL};
        cnt_n   = cnt - 1'b1;
      end else begin
        done_n = 1'b1;
        if (LOAD_VALID) begin
          shreg_n = D;
          cnt_n   = CW'(WIDTH - 1);
        end else begin
          state_n = IDLE;
          shreg_n = {WIDTH{IDLE_LEVEL}};
        end
      end
    end
  end
endmodule

// File: doc/piso_serializer_handshake.md
Name: piso_serializer_handshake

Overview:
Parallel-in/serial-out serializer that sits directly upstream of the team's 8-bit serial-in/serial-out shift registers. It accepts a parallel word through a valid/ready handshake and drives it MSB-first on SO, one bit per clock-enable-qualified rising edge of C. Back-to-back words stream with no idle gap. A count-based state machine provides framing (SO_VALID, BUSY, DONE).

Parameters:
WIDTH, 8, word length in bits; legal range is WIDTH >= 2.
IDLE_LEVEL, 1'b1, level driven on SO when idle, and fill bit shifted into the vacated LSB.

Ports:
C  input  1  clock; all state updates on rising edge.
CLR  input  1  asynchronous active-low reset; 0 resets immediately, independent of C.
D  input  WIDTH  parallel word; sampled only when a load is accepted.
LOAD_VALID  input  1  upstream has a word on D.
LOAD_READY  output  1  block can accept D this cycle (combinational).
CE  input  1  shift enable; when 0, all state holds.
SO  output  1  serial data out, MSB first.
SO_VALID  output  1  SO carries a payload bit.
BUSY  output  1  word in flight (state SHIFT).
DONE  output  1  registered one-cycle pulse after the last bit's shift edge.

Behaviour:
- Reset (CLR=0, asynchronous):
  - state=IDLE, shreg = all IDLE_LEVEL, cnt=0, DONE=0.
  - Outputs while CLR=0: SO=IDLE_LEVEL, SO_VALID=0, BUSY=0, LOAD_READY=0.
- cnt is $clog2(WIDTH) bits wide. It counts remaining bits after the current one.
- States: IDLE and SHIFT.
- IDLE:
  - LOAD_READY=1, SO=IDLE_LEVEL, SO_VALID=0, BUSY=0.
  - On an edge with LOAD_VALID=1: shreg<=D, cnt<=WIDTH-1, state<=SHIFT.
  - A load in IDLE is accepted regardless of CE.
- SHIFT:
  - SO=shreg[WIDTH-1], SO_VALID=1, BUSY=1.
  - Edge with CE=0: everything holds and DONE<=0.
  - Edge with CE=1 and cnt!=0: shreg<={shreg[WIDTH-2:0],IDLE_LEVEL}, cnt<=cnt-1.
  - Edge with CE=1 and cnt==0 (last bit): DONE<=1.
    - If LOAD_VALID=1: shreg<=D, cnt<=WIDTH-1, stay in SHIFT (zero-gap streaming).
    - Otherwise: state<=IDLE, shreg<=all IDLE_LEVEL.
- LOAD_READY = (state==IDLE) | (state==SHIFT & cnt==0 & CE). It is combinational from state, cnt and CE.
- Handshake: a transfer occurs only on an edge where LOAD_VALID & LOAD_READY are both 1. LOAD_VALID while LOAD_READY=0 is ignored; D is not captured.
- Latency: for a word accepted at edge k, the MSB is on SO after edge k. Bit i (MSB=0) is on SO during the i-th CE-qualified cycle after acceptance. A word therefore occupies exactly WIDTH CE=1 cycles.
- DONE is 0 on every edge except the last-bit edge.
- CE stall on the last bit: LOAD_READY=0, so no reload occurs until the CE=1 edge.
- CLR mid-word: the word is discarded immediately. After CLR is released the block is in IDLE and accepts a new word on the next edge.

Test Plan:
- Reset: hold CLR=0 with C toggling and LOAD_VALID=1, D=8'hFF -> SO=1, SO_VALID=0, BUSY=0, LOAD_READY=0 throughout; release -> LOAD_READY=1 at the first cycle.
- Single word: D=8'hA5, LOAD_VALID one cycle, CE=1 -> SO sequence 1,0,1,0,0,1,0,1 with SO_VALID=1 for exactly 8 cycles; DONE high one cycle after the 8th shift edge; then IDLE with SO=1.
- Back-to-back: 8'hA5 then 8'h3C, LOAD_VALID held -> 16 contiguous SO_VALID cycles, SO = 10100101 00111100, DONE pulses twice, no idle cycle between words.
- CE stall: 8'hC3 with CE=0 for 3 cycles after the 2nd bit -> SO holds 1 during the stall; full sequence 1,1,0,0,0,0,1,1; SO_VALID spans 11 cycles; D changes during the stall have no effect.
- Ignored load / reset mid-word: LOAD_VALID with D=8'h00 during bit 4 of 8'hF0 -> output unchanged (11110000). Next, CLR=0 asynchronously during bit 3 of 8'h81 -> SO=1 and SO_VALID=0 immediately, no DONE pulse.
- Integration: drive SO into the downstream 8-bit SISO shift register's SI on the same C, with word 8'h5A -> after the 8 shift edges its internal register equals 8'h5A.
